// File: rtl/cpu16_mem_arbiter_pkg.sv
// Shared types and memory-map constants for the cpu16 memory arbiter.
package cpu16_mem_pkg;

  // Which CPU grant is waiting for its rdy pulse in the following cycle.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_INS,
    TAG_DAT_RD,
    TAG_DAT_WR
  } tag_e;

  localparam logic [3:0]  RAM_PAGE      = 4'h0;
  localparam logic [3:0]  VRAM_PAGE     = 4'h8;
  localparam logic [3:0]  CTRL_PAGE     = 4'hF;
  localparam logic [15:0] UNMAPPED_DATA = 16'hEEEE;

  function automatic logic [3:0] page_of(input logic [15:0] addr);
    return addr[15:12];
  endfunction

endpackage

// File: rtl/cpu16_mem_arbiter_if.sv
// Requester and memory-port bundle between cpu16, the debug writer and SRAM.
interface cpu16_mem_arbiter_if;
  logic        dbg_we;
  logic [15:0] dbg_waddr;
  logic [15:0] dbg_wdata;
  logic [15:0] ins_rd_addr;
  logic        ins_rd_req;
  logic        ins_rd_rdy;
  logic [15:0] ins_rd_data;
  logic [15:0] dat_rw_addr;
  logic [15:0] dat_wr_data;
  logic        dat_rd_req;
  logic        dat_rd_rdy;
  logic [15:0] dat_rd_data;
  logic        dat_wr_req;
  logic        dat_wr_rdy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  modport slave (
    input  dbg_we, dbg_waddr, dbg_wdata,
    input  ins_rd_addr, ins_rd_req,
    output ins_rd_rdy, ins_rd_data,
    input  dat_rw_addr, dat_wr_data, dat_rd_req, dat_wr_req,
    output dat_rd_rdy, dat_rd_data, dat_wr_rdy,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output dbg_we, dbg_waddr, dbg_wdata,
    output ins_rd_addr, ins_rd_req,
    input  ins_rd_rdy, ins_rd_data,
    output dat_rw_addr, dat_wr_data, dat_rd_req, dat_wr_req,
    input  dat_rd_rdy, dat_rd_data, dat_wr_rdy,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/cpu16_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with per-requester mask; bit 0 = ins, bit 1 = dat.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] elig;
  logic       last;  // 0: requester 0 had the last grant, 1: requester 1

  assign elig = req & ~mask;

  always_comb begin
    gnt    = 2'b00;
    gnt[1] = elig[1] & (~elig[0] | ~last);
    gnt[0] = elig[0] & (~elig[1] |  last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last <= 1'b0;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/cpu16_mem_arbiter.sv
// Serialises debug writes, CPU data and CPU fetch onto one SRAM port and returns rdy/data.
module cpu16_mem_arbiter #(
  parameter logic [3:0]  RAM_PAGE      = cpu16_mem_pkg::RAM_PAGE,
  parameter logic [15:0] UNMAPPED_DATA = cpu16_mem_pkg::UNMAPPED_DATA
) (
  input  logic                clk,
  input  logic                reset,
  cpu16_mem_arbiter_if.slave  bus
);
  import cpu16_mem_pkg::*;

  tag_e        tag_q, tag_d;
  logic [3:0]  rd_page_q;
  logic [1:0]  req, mask, gnt;
  logic [15:0] addr_c, wdata_c, rd_data;
  logic        we_c, re_c;

  // A port granted last cycle is masked so its held request is not served twice.
  assign req  = {bus.dat_rd_req | bus.dat_wr_req, bus.ins_rd_req};
  assign mask = {bus.dbg_we | (tag_q == TAG_DAT_RD) | (tag_q == TAG_DAT_WR),
                 bus.dbg_we | (tag_q == TAG_INS)};

  rr_arb2 u_rr (
    .clk  (clk),
    .rst  (reset),
    .req  (req),
    .mask (mask),
    .gnt  (gnt)
  );

  always_comb begin
    tag_d   = TAG_NONE;
    addr_c  = 16'h0000;
    wdata_c = 16'h0000;
    we_c    = 1'b0;
    re_c    = 1'b0;
    if (bus.dbg_we) begin
      we_c    = 1'b1;
      addr_c  = bus.dbg_waddr;
      wdata_c = bus.dbg_wdata;
    end else if (gnt[1]) begin
      addr_c = bus.dat_rw_addr;
      if (bus.dat_wr_req) begin
        we_c    = 1'b1;
        wdata_c = bus.dat_wr_data;
        tag_d   = TAG_DAT_WR;
      end else begin
        re_c  = 1'b1;
        tag_d = TAG_DAT_RD;
      end
    end else if (gnt[0]) begin
      addr_c = bus.ins_rd_addr;
      re_c   = 1'b1;
      tag_d  = TAG_INS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q     <= TAG_NONE;
      rd_page_q <= 4'h0;
    end else begin
      tag_q <= tag_d;
      if (re_c) rd_page_q <= page_of(addr_c);
    end
  end

  // Only the RAM page is readable; vram is write-only and ctrl reads are stubbed.
  assign rd_data = (rd_page_q == RAM_PAGE) ? bus.mem_rdata : UNMAPPED_DATA;

  assign bus.mem_addr    = addr_c;
  assign bus.mem_wdata   = wdata_c;
  assign bus.mem_we      = we_c & ~reset;
  assign bus.mem_re      = re_c & ~reset;
  assign bus.ins_rd_rdy  = (tag_q == TAG_INS);
  assign bus.dat_rd_rdy  = (tag_q == TAG_DAT_RD);
  assign bus.dat_wr_rdy  = (tag_q == TAG_DAT_WR);
  assign bus.ins_rd_data = rd_data;
  assign bus.dat_rd_data = rd_data;

endmodule

// File: tb/tb_cpu16_mem_arbiter.sv
// Scoreboard bench for cpu16_mem_arbiter with a behavioural single-port SRAM.
module tb_cpu16_mem_arbiter;
  import cpu16_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   dwr_pend = 0;

  logic [15:0] sram   [0:4095];
  logic [15:0] shadow [0:4095];
  logic [15:0] ins_q [$];
  logic [15:0] drd_q [$];

  cpu16_mem_arbiter_if bus();

  cpu16_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = i[15:0];
    return (i == 16) ? 16'h1234 : (16'hA000 ^ v);
  endfunction

  function automatic logic [15:0] expect_rd(input logic [15:0] a);
    return (a[15:12] == RAM_PAGE) ? shadow[a[11:0]] : UNMAPPED_DATA;
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // SRAM: registered read, page-0 writes only.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) sram[i] <= init_val(i);
    end else begin
      if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr[11:0]];
      if (bus.mem_we && bus.mem_addr[15:12] == 4'h0) sram[bus.mem_addr[11:0]] <= bus.mem_wdata;
    end
  end

  // Scoreboard side: pop expectations as rdy pulses appear.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rdy_onehot", 16'($countones({bus.ins_rd_rdy, bus.dat_rd_rdy, bus.dat_wr_rdy}) <= 1), 16'd1);
      if (bus.ins_rd_rdy) begin
        if (ins_q.size() == 0) chk("ins_unexp", 16'(bus.ins_rd_rdy), 16'd0);
        else chk("ins_data", bus.ins_rd_data, ins_q.pop_front());
      end
      if (bus.dat_rd_rdy) begin
        if (drd_q.size() == 0) chk("drd_unexp", 16'(bus.dat_rd_rdy), 16'd0);
        else chk("drd_data", bus.dat_rd_data, drd_q.pop_front());
      end
      if (bus.dat_wr_rdy) begin
        if (dwr_pend == 0) chk("dwr_unexp", 16'(bus.dat_wr_rdy), 16'd0);
        else dwr_pend--;
      end
    end
  end

  // Request tasks: entered on a negedge, return on the negedge where rdy is seen.
  task automatic fetch(input logic [15:0] a);
    bit got;
    got = 1'b0;
    bus.ins_rd_addr = a;
    bus.ins_rd_req  = 1'b1;
    ins_q.push_back(expect_rd(a));
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = bus.ins_rd_rdy;
    end
    if (!got) chk("ins_timeout", 16'(got), 16'd1);
    bus.ins_rd_req = 1'b0;
  endtask

  task automatic dat_read(input logic [15:0] a);
    bit got;
    got = 1'b0;
    bus.dat_rw_addr = a;
    bus.dat_rd_req  = 1'b1;
    drd_q.push_back(expect_rd(a));
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = bus.dat_rd_rdy;
    end
    if (!got) chk("drd_timeout", 16'(got), 16'd1);
    bus.dat_rd_req = 1'b0;
  endtask

  task automatic dat_write(input logic [15:0] a, input logic [15:0] d);
    bit got;
    got = 1'b0;
    bus.dat_rw_addr = a;
    bus.dat_wr_data = d;
    bus.dat_wr_req  = 1'b1;
    dwr_pend++;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = bus.dat_wr_rdy;
    end
    if (!got) chk("dwr_timeout", 16'(got), 16'd1);
    if (a[15:12] == RAM_PAGE) shadow[a[11:0]] = d;
    bus.dat_wr_req = 1'b0;
  endtask

  initial begin
    int c0;
    bus.dbg_we = 1'b0;      bus.dbg_waddr = 16'h0;   bus.dbg_wdata = 16'h0;
    bus.ins_rd_addr = 16'h0; bus.ins_rd_req = 1'b0;
    bus.dat_rw_addr = 16'h0; bus.dat_wr_data = 16'h0;
    bus.dat_rd_req = 1'b0;  bus.dat_wr_req = 1'b0;
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);

    repeat (3) @(negedge clk);
    chk("rst_ins_rdy", 16'(bus.ins_rd_rdy), 16'd0);
    chk("rst_drd_rdy", 16'(bus.dat_rd_rdy), 16'd0);
    chk("rst_dwr_rdy", 16'(bus.dat_wr_rdy), 16'd0);
    chk("rst_mem_we",  16'(bus.mem_we), 16'd0);
    reset = 1'b0;
    @(negedge clk);

    // Async reset in the middle of a pending fetch.
    bus.ins_rd_addr = 16'h0010;
    bus.ins_rd_req  = 1'b1;
    #1 chk("pre_rst_re", 16'(bus.mem_re), 16'd1);
    #1 reset = 1'b1;
    #1 chk("rst_async_re", 16'(bus.mem_re), 16'd0);
    chk("rst_async_rdy", 16'(bus.ins_rd_rdy), 16'd0);
    @(negedge clk);
    chk("rst_hold_rdy", 16'(bus.ins_rd_rdy), 16'd0);
    reset = 1'b0;
    ins_q.push_back(expect_rd(16'h0010));
    #1 chk("rel_grant_re", 16'(bus.mem_re), 16'd1);
    chk("rel_grant_addr", bus.mem_addr, 16'h0010);
    @(negedge clk);
    chk("fetch_rdy_n1", 16'(bus.ins_rd_rdy), 16'd1);
    chk("fetch_no_regrant", 16'(bus.mem_re), 16'd0);
    bus.ins_rd_req = 1'b0;
    @(negedge clk);

    // Round-robin: both ports busy, one grant per cycle, data first after an ins grant.
    c0 = cyc;
    fork
      for (int i = 0; i < 4; i++) fetch(16'h0010 + 16'(i));
      for (int i = 0; i < 4; i++) dat_read(16'h0003 + 16'(i));
      begin
        @(negedge clk);
        chk("rr_first_dat", 16'(bus.dat_rd_rdy), 16'd1);
      end
    join
    chk("rr_cycles", 16'(cyc - c0), 16'd8);

    // Debug write beats a data write, which is then served the next cycle.
    bus.dbg_we = 1'b1;
    bus.dbg_waddr = {VRAM_PAGE, 12'h005};
    bus.dbg_wdata = 16'h0041;
    bus.dat_rw_addr = 16'h0020;
    bus.dat_wr_data = 16'hCAFE;
    bus.dat_wr_req = 1'b1;
    dwr_pend++;
    #1 chk("dbg_we", 16'(bus.mem_we), 16'd1);
    chk("dbg_addr", bus.mem_addr, 16'h8005);
    chk("dbg_wdata", bus.mem_wdata, 16'h0041);
    @(negedge clk);
    bus.dbg_we = 1'b0;
    chk("dbg_no_rdy", 16'(bus.dat_wr_rdy), 16'd0);
    #1 chk("dwr_we", 16'(bus.mem_we), 16'd1);
    chk("dwr_addr", bus.mem_addr, 16'h0020);
    chk("dwr_wdata", bus.mem_wdata, 16'hCAFE);
    @(negedge clk);
    chk("dwr_rdy", 16'(bus.dat_wr_rdy), 16'd1);
    bus.dat_wr_req = 1'b0;
    shadow[12'h020] = 16'hCAFE;
    @(negedge clk);

    // Fetch colliding with a debug write to the same word is retried next cycle.
    bus.dbg_we = 1'b1;
    bus.dbg_waddr = 16'h0040;
    bus.dbg_wdata = 16'h7777;
    bus.ins_rd_addr = 16'h0040;
    bus.ins_rd_req = 1'b1;
    shadow[12'h040] = 16'h7777;
    ins_q.push_back(expect_rd(16'h0040));
    #1 chk("coll_re", 16'(bus.mem_re), 16'd0);
    chk("coll_we", 16'(bus.mem_we), 16'd1);
    @(negedge clk);
    bus.dbg_we = 1'b0;
    chk("coll_no_rdy", 16'(bus.ins_rd_rdy), 16'd0);
    #1 chk("coll_retry_re", 16'(bus.mem_re), 16'd1);
    @(negedge clk);
    chk("coll_rdy", 16'(bus.ins_rd_rdy), 16'd1);
    bus.ins_rd_req = 1'b0;
    @(negedge clk);

    // Unmapped pages, SRAM contents, write-then-read.
    dat_read({CTRL_PAGE, 12'h000});
    dat_read(16'h0003);
    dat_read({VRAM_PAGE, 12'h005});
    dat_read(16'h0020);
    dat_write(16'h0030, 16'hBEEF);
    dat_read(16'h0030);
    @(negedge clk);
    fetch(16'h0030);

    repeat (2) @(negedge clk);
    chk("ins_q_drained", 16'(ins_q.size()), 16'd0);
    chk("drd_q_drained", 16'(drd_q.size()), 16'd0);
    chk("dwr_drained", 16'(dwr_pend), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
